// File: rtl/imem_sync.sv
// Synchronous instruction memory: byte-addressed valid/ready fetch with a
// configurable response latency, fault flagging and a run-time program port.
module imem_sync #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 128,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 1,
   parameter int PIDX_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_fault,
   input  logic              prog_we,
   input  logic [PIDX_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              fault_q, fault_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-3:0] word_idx;
   logic [PIDX_W-1:0] rd_idx;
   logic              misalign;
   logic              range_err;
   logic              req_fault;
   logic [DATA_W-1:0] rd_word;
   logic              prog_in_range;

   assign word_idx  = req_addr[ADDR_W-1:2];
   assign rd_idx    = word_idx[PIDX_W-1:0];
   assign misalign  = |req_addr[1:0];
   assign range_err = (word_idx >= (ADDR_W-2)'(DEPTH));
   assign req_fault = misalign | range_err;
   // Truncated index is only dereferenced when the full index is in range.
   assign rd_word   = req_fault ? '0 : mem_q[rd_idx];

   assign prog_in_range = ({1'b0, prog_addr} < (PIDX_W+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (prog_we && prog_in_range) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      fault_d = fault_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               fault_d = req_fault;
               data_d  = rd_word;
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         fault_q <= fault_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_data  = resp_valid ? data_q : '0;
   assign resp_fault = resp_valid & fault_q;

endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: three instances (LATENCY 1, 3, 4) share the
// program port and address; a reference memory array predicts every response.
module tb_imem_sync;

   localparam int DEPTH = 128;
   localparam int NI    = 3;

   logic        clk;
   logic        rst_n;
   logic [31:0] req_addr;
   logic [2:0]  rv, rdy, rvld, rr, rflt;
   logic [31:0] rdata [NI];
   logic        prog_we;
   logic [6:0]  prog_addr;
   logic [31:0] prog_data;

   typedef struct {
      int          inst;
      logic [31:0] data;
      logic        fault;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [DEPTH];
   bit          started [NI];
   int          cyc;
   int          tests;
   int          fails;
   int          rr_mode;

   function automatic int lat(input int g);
      return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      imem_sync #(
         .DATA_W (32),
         .DEPTH  (DEPTH),
         .ADDR_W (32),
         .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
         .PIDX_W (7)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (rv[g]),
         .req_ready (rdy[g]),
         .req_addr  (req_addr),
         .resp_valid(rvld[g]),
         .resp_ready(rr[g]),
         .resp_data (rdata[g]),
         .resp_fault(rflt[g]),
         .prog_we   (prog_we),
         .prog_addr (prog_addr),
         .prog_data (prog_data)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference rule: fault on misalignment or word index beyond DEPTH; faulted data is 0.
   task automatic push_exp(input int g, input logic [31:0] a, input int when);
      exp_t e;
      logic [31:0] idx;
      idx     = a >> 2;
      e.inst  = g;
      e.fault = (a[1:0] != 2'b00) || (idx >= DEPTH);
      e.data  = e.fault ? 32'h0 : model[idx];
      e.cyc   = when;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      for (int g = 0; g < NI; g++) begin
         if (rr_mode == 1)      rr[g] = 1'b1;
         else if (rr_mode == 2) rr[g] = 1'b0;
         else                   rr[g] = ($urandom_range(0, 3) != 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int g = 0; g < NI; g++) begin
            int idx;
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
               if (sb[i].inst == g) begin
                  idx = i;
                  break;
               end
            end
            if (rvld[g]) begin
               if (idx < 0) begin
                  chk($sformatf("unexpected_resp_%0d", g), 64'd1, 64'd0);
               end else begin
                  chk($sformatf("data_%0d", g), 64'(rdata[g]), 64'(sb[idx].data));
                  chk($sformatf("fault_%0d", g), 64'(rflt[g]), 64'(sb[idx].fault));
                  chk($sformatf("ready_in_resp_%0d", g), 64'(rdy[g]), 64'd0);
                  if (!started[g]) begin
                     chk($sformatf("latency_%0d", g), 64'(cyc), 64'(sb[idx].cyc));
                     started[g] = 1'b1;
                  end
                  if (rr[g]) begin
                     sb.delete(idx);
                     started[g] = 1'b0;
                  end
               end
            end else begin
               chk($sformatf("idle_zero_%0d", g), {31'd0, rflt[g], rdata[g]}, 64'd0);
            end
         end
      end
   end

   task automatic prog(input logic [6:0] wa, input logic [31:0] wd);
      @(negedge clk); #1;
      prog_we = 1'b1; prog_addr = wa; prog_data = wd;
      @(posedge clk);
      model[wa] = wd;
      #1;
      prog_we = 1'b0;
   endtask

   // Issue the same fetch to every instance; each drops req_valid once accepted.
   task automatic fetch_all(input logic [31:0] a, input bit we, input logic [6:0] wa,
                            input logic [31:0] wd, input bit rndw);
      logic [2:0] acc;
      int n;
      n = 0;
      @(negedge clk); #1;
      req_addr = a; rv = 3'b111;
      prog_we = we; prog_addr = wa; prog_data = wd;
      while (rv != 3'b000 && n < 200) begin
         acc = rv & rdy;
         for (int g = 0; g < NI; g++) if (acc[g]) push_exp(g, a, cyc + lat(g));
         @(posedge clk);
         if (prog_we) model[prog_addr] = prog_data;
         #1;
         rv = rv & ~acc;
         prog_we = 1'b0;
         @(negedge clk); #1;
         if (rndw && $urandom_range(0, 3) == 0) begin
            prog_we = 1'b1;
            prog_addr = 7'($urandom_range(0, DEPTH - 1));
            prog_data = $urandom;
         end
         n++;
      end
      prog_we = 1'b0;
      if (rv != 3'b000) begin
         chk("accept_timeout", 64'(rv), 64'd0);
         rv = 3'b000;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int r;
      tests = 0; fails = 0; rr_mode = 1;
      rst_n = 1'b0; rv = 3'b000; req_addr = '0; rr = 3'b111;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      for (int g = 0; g < NI; g++) started[g] = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("reset_ready", 64'(rdy), 64'h7);
      chk("reset_valid", 64'(rvld), 64'h0);
      chk("reset_data0", 64'(rdata[0]), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) prog(7'(i), $urandom);
      prog(7'd3, 32'h8C12_3456);
      prog(7'd5, 32'hAD65_4321);

      // In-order sequential fetches with the consumer always ready.
      rr_mode = 1;
      for (int i = 0; i <= 8; i++) fetch_all(32'(i * 4), 1'b0, '0, '0, 1'b0);
      drain();

      // Held response: data must stay stable while resp_ready is low.
      rr_mode = 2;
      fetch_all(32'h0000_000C, 1'b0, '0, '0, 1'b0);
      repeat (9) @(negedge clk);
      rr_mode = 1;
      drain();

      fetch_all(32'h0000_0006, 1'b0, '0, '0, 1'b0);
      drain();
      fetch_all(32'h0000_0200, 1'b0, '0, '0, 1'b0);
      drain();
      fetch_all(32'h0000_0004, 1'b0, '0, '0, 1'b0);
      drain();

      // Same-edge write returns the old word; the next fetch sees the new one.
      fetch_all(32'h0000_0014, 1'b1, 7'd5, 32'h1234_5678, 1'b0);
      drain();
      fetch_all(32'h0000_0014, 1'b0, '0, '0, 1'b0);
      drain();

      // Reset mid-WAIT: the in-flight request must vanish without a response.
      @(negedge clk); #1;
      req_addr = 32'h0000_000C; rv = 3'b111;
      for (int g = 0; g < NI; g++) if (rdy[g]) push_exp(g, req_addr, cyc + lat(g));
      @(posedge clk); #1;
      rv = 3'b000;
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(rvld), 64'h0);
      chk("rst_ready", 64'(rdy), 64'h7);
      chk("rst_data", {rdata[1], rdata[2]}, 64'h0);
      chk("rst_fault", 64'(rflt), 64'h0);
      sb.delete();
      for (int g = 0; g < NI; g++) started[g] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      fetch_all(32'h0000_000C, 1'b0, '0, '0, 1'b0);
      drain();
      fetch_all(32'h0000_0014, 1'b0, '0, '0, 1'b0);
      drain();

      // Randomised mix with back-pressure and concurrent program writes.
      rr_mode = 0;
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         a = {23'd0, 7'($urandom_range(0, DEPTH - 1)), 2'b00};
         if (r == 7)      a = a | 32'($urandom_range(1, 3));
         else if (r >= 8) a = 32'($urandom_range(DEPTH * 4, 32'h7FFF_FFFF));
         fetch_all(a, 1'b0, '0, '0, 1'b1);
      end
      rr_mode = 1;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
